// File: rtl/raster_dispatch_if.sv
// Triangle payload type and the setup/rasterizer handshake bundle for raster_dispatch.
// master = environment side (setup + rasterizer), slave = dispatcher side.
package raster_dispatch_pkg;
    localparam int unsigned COORD_W = 12;
    localparam int unsigned ID_W    = 16;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] min_x;
        logic [COORD_W-1:0] max_x;
        logic [COORD_W-1:0] min_y;
        logic [COORD_W-1:0] max_y;
        logic [ID_W-1:0]    tri_id;
    } triangle_setup_t;
endpackage

interface raster_dispatch_if;
    import raster_dispatch_pkg::*;

    triangle_setup_t in_tri;
    logic            in_valid;
    logic            in_ready;
    triangle_setup_t rast_tri;
    logic            rast_start;
    logic            rast_done;
    logic            rast_busy;

    modport master (
        output in_tri, in_valid, rast_done, rast_busy,
        input  in_ready, rast_tri, rast_start
    );

    modport slave (
        input  in_tri, in_valid, rast_done, rast_busy,
        output in_ready, rast_tri, rast_start
    );
endinterface

// File: rtl/raster_dispatch.sv
// Triangle scheduler: queues setup results, culls empty boxes, issues one triangle at a time.
// Optional perf counters are built only when RAST_DISPATCH_PERF_EN is defined.
module raster_dispatch
    import raster_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    raster_dispatch_if.slave bus,
    input  logic             flush,
    input  logic             frag_valid,
    input  logic             frag_ready,
    output logic             idle,
    output logic [CNT_W-1:0] tri_count,
    output logic [CNT_W-1:0] cull_count,
    output logic [CNT_W-1:0] frag_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] busy_cycles
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_QW = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    triangle_setup_t mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_QW-1:0] count_q, count_d;
    triangle_setup_t rast_tri_q, rast_tri_d;
    logic            rast_start_q;
    logic            idle_q;
    logic [CNT_W-1:0] tri_count_q;

    logic full, empty, accept, cull_c, push, pop;

    // Input side: empty bounding boxes are consumed without occupying a slot
    assign full         = (count_q == CNT_QW'(DEPTH));
    assign empty        = (count_q == '0);
    assign bus.in_ready = !full && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign cull_c       = !bus.in_tri.valid || (bus.in_tri.min_x > bus.in_tri.max_x) ||
                          (bus.in_tri.min_y > bus.in_tri.max_y);
    assign push         = accept && !cull_c;

    // Next-state and held-triangle update
    always_comb begin
        state_d    = state_q;
        rast_tri_d = rast_tri_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !bus.rast_busy) begin
                    pop        = 1'b1;
                    rast_tri_d = mem[rd_ptr_q];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.rast_done) begin
                    rast_tri_d.valid = 1'b0;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Occupancy; flush drops everything still queued, a same-cycle pop already took its entry
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_QW'(push) - CNT_QW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.in_tri;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rast_tri_q   <= '0;
            rast_start_q <= 1'b0;
            idle_q       <= 1'b1;
            tri_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            rast_tri_q   <= rast_tri_d;
            rast_start_q <= (state_d == ST_ISSUE);
            idle_q       <= (count_d == '0) && (state_d == ST_IDLE) && !bus.rast_busy;
            if (rast_start_q) tri_count_q <= tri_count_q + CNT_W'(1);
        end
    end

    assign bus.rast_tri   = rast_tri_q;
    assign bus.rast_start = rast_start_q;
    assign idle           = idle_q;
    assign tri_count      = tri_count_q;

`ifdef RAST_DISPATCH_PERF_EN
    logic [CNT_W-1:0] cull_q, frag_q, stall_q, busy_q;

    // Fragment handshake and rasterizer occupancy snoop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cull_q  <= '0;
            frag_q  <= '0;
            stall_q <= '0;
            busy_q  <= '0;
        end else begin
            if (accept && cull_c)            cull_q  <= cull_q + CNT_W'(1);
            if (frag_valid && frag_ready)    frag_q  <= frag_q + CNT_W'(1);
            if (frag_valid && !frag_ready)   stall_q <= stall_q + CNT_W'(1);
            if (bus.rast_busy)               busy_q  <= busy_q + CNT_W'(1);
        end
    end

    assign cull_count  = cull_q;
    assign frag_count  = frag_q;
    assign stall_count = stall_q;
    assign busy_cycles = busy_q;
`else
    logic unused_perf;
    assign unused_perf = ^{frag_valid, frag_ready};

    assign cull_count  = '0;
    assign frag_count  = '0;
    assign stall_count = '0;
    assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_raster_dispatch.sv
// Scoreboard bench for raster_dispatch with a behavioural rasterizer model.
module tb_raster_dispatch;
    import raster_dispatch_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 32;
`ifdef RAST_DISPATCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush, frag_valid, frag_ready, idle;
    logic [CNT_W-1:0] tri_count, cull_count, frag_count, stall_count, busy_cycles;

    always #5 clk = ~clk;

    raster_dispatch_if bus();

    raster_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
        .frag_valid(frag_valid), .frag_ready(frag_ready), .idle(idle),
        .tri_count(tri_count), .cull_count(cull_count), .frag_count(frag_count),
        .stall_count(stall_count), .busy_cycles(busy_cycles)
    );

    int n_checks = 0;
    int n_errors = 0;
    triangle_setup_t exp_q[$];
    int run_len = 4;
    bit force_busy = 1'b0;
    bit stray_done = 1'b0;
    bit active = 1'b0;
    bit changed, chk_clr, prev_start;
    int run_cnt;
    int busy_ref = 0;
    triangle_setup_t cur_tri;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic triangle_setup_t mk(input logic v, input int unsigned x0, input int unsigned y0,
                                           input int unsigned x1, input int unsigned y1,
                                           input int unsigned id);
        triangle_setup_t r;
        r.valid  = v;
        r.min_x  = COORD_W'(x0);
        r.min_y  = COORD_W'(y0);
        r.max_x  = COORD_W'(x1);
        r.max_y  = COORD_W'(y1);
        r.tri_id = ID_W'(id);
        return r;
    endfunction

    function automatic bit culled(input triangle_setup_t t);
        return !t.valid || (t.min_x > t.max_x) || (t.min_y > t.max_y);
    endfunction

    // Rasterizer model: runs run_len cycles per start, checks issue order and stability
    initial begin
        triangle_setup_t e;
        bus.rast_done = 1'b0;
        bus.rast_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0; chk_clr = 1'b0; prev_start = 1'b0; busy_ref = 0;
                bus.rast_done = 1'b0; bus.rast_busy = 1'b0;
                continue;
            end
            if (bus.rast_busy) busy_ref++;
            bus.rast_done = 1'b0;
            if (chk_clr) begin
                chk_clr = 1'b0;
                e = cur_tri;
                e.valid = 1'b0;
                check("tri_cleared", 128'(bus.rast_tri), 128'(e));
            end
            if (active) begin
                if (bus.rast_tri !== cur_tri) changed = 1'b1;
                if (run_cnt == 0) begin
                    bus.rast_done = 1'b1;
                    active = 1'b0;
                    chk_clr = 1'b1;
                    check("tri_stable", 128'(changed), 128'(0));
                end else begin
                    run_cnt--;
                end
            end else if (stray_done) begin
                bus.rast_done = 1'b1;
            end
            if (bus.rast_start) begin
                check("start_width", 128'(prev_start), 128'(0));
                check("start_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rast_tri", 128'(bus.rast_tri), 128'(e));
                end
                cur_tri = bus.rast_tri;
                changed = 1'b0;
                active  = 1'b1;
                run_cnt = run_len;
            end
            prev_start = bus.rast_start;
            bus.rast_busy = active || force_busy;
        end
    end

    task automatic push(input triangle_setup_t t);
        int cyc = 0;
        @(negedge clk);
        bus.in_tri   = t;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("push_accept", 128'(bus.in_ready), 128'(1));
        if (bus.in_ready && !culled(t)) exp_q.push_back(t);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (!(exp_q.size() == 0 && !active && idle && !bus.rast_busy) && cyc < 500);
        check({tag, "_idle_wait"}, 128'(cyc < 500), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rdy_mask;
        flush = 1'b0; frag_valid = 1'b0; frag_ready = 1'b0;
        bus.in_valid = 1'b0; bus.in_tri = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_idle", 128'(idle), 128'(1));
        check("rst_start", 128'(bus.rast_start), 128'(0));
        check("rst_tri", 128'(bus.rast_tri), 128'(0));
        check("rst_tri_count", 128'(tri_count), 128'(0));
        check("rst_cull_count", 128'(cull_count), 128'(0));

        // Single triangle latency and completion
        push(mk(1'b1, 0, 0, 3, 3, 1));
        @(negedge clk); #1;
        check("t1_no_early_start", 128'(bus.rast_start), 128'(0));
        @(negedge clk); #1;
        check("t1_start", 128'(bus.rast_start), 128'(1));
        @(negedge clk); #1;
        check("t1_start_pulse", 128'(bus.rast_start), 128'(0));
        wait_idle("t1");
        check("t1_tri_count", 128'(tri_count), 128'(1));
        check("t1_idle", 128'(idle), 128'(1));

        // Backpressure: queue fills while rasterizer busy, fifth waits for first pop
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) push(mk(1'b1, i, i, i + 4, i + 2, 16 + i));
        check("t2_full", 128'(bus.in_ready), 128'(0));
        check("t2_no_start", 128'(tri_count), 128'(1));
        fork
            push(mk(1'b1, 7, 8, 9, 10, 20));
            begin
                repeat (3) @(negedge clk);
                #1;
                check("t2_still_full", 128'(bus.in_ready), 128'(0));
                force_busy = 1'b0;
            end
        join
        wait_idle("t2");
        check("t2_tri_count", 128'(tri_count), 128'(6));

        // Culled inputs and a stray done while idle
        push(mk(1'b1, 10, 0, 9, 5, 30));
        push(mk(1'b0, 0, 0, 3, 3, 31));
        repeat (5) @(negedge clk);
        #1;
        check("t3_tri_count", 128'(tri_count), 128'(6));
        check("t3_idle", 128'(idle), 128'(1));
        check("t3_cull_count", 128'(cull_count), PERF ? 128'(2) : 128'(0));
        stray_done = 1'b1;
        repeat (2) @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t3_stray_done_count", 128'(tri_count), 128'(6));
        check("t3_stray_done_idle", 128'(idle), 128'(1));

        // Flush during the first triangle's run
        run_len = 8;
        for (int i = 0; i < 3; i++) push(mk(1'b1, 1, 2, 5 + i, 6, 40 + i));
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("t4_flush_ready", 128'(bus.in_ready), 128'(0));
        check("t4_in_flight", 128'(bus.rast_tri.valid), 128'(1));
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0;
        wait_idle("t4");
        repeat (10) @(negedge clk);
        #1;
        check("t4_tri_count", 128'(tri_count), 128'(7));
        check("t4_ready", 128'(bus.in_ready), 128'(1));

        // Fragment snoop with a triangle in flight
        run_len = 6;
        rdy_mask = 8'b1101_0110;
        push(mk(1'b1, 2, 2, 8, 8, 50));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            frag_valid = 1'b1;
            frag_ready = rdy_mask[i];
        end
        @(negedge clk);
        frag_valid = 1'b0;
        frag_ready = 1'b0;
        @(negedge clk); #1;
        check("t5_frag_count", 128'(frag_count), PERF ? 128'(5) : 128'(0));
        check("t5_stall_count", 128'(stall_count), PERF ? 128'(3) : 128'(0));
        wait_idle("t5");
        check("t5_busy_cycles", 128'(busy_cycles), PERF ? 128'(busy_ref) : 128'(0));
        check("t5_tri_count", 128'(tri_count), 128'(8));
        check("t5_cull_count", 128'(cull_count), PERF ? 128'(2) : 128'(0));

        // Reset mid-run with triangles queued
        run_len = 10;
        for (int i = 0; i < 3; i++) push(mk(1'b1, 3, 3, 4 + i, 4, 60 + i));
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_start", 128'(bus.rast_start), 128'(0));
        check("t6_tri", 128'(bus.rast_tri), 128'(0));
        check("t6_tri_count", 128'(tri_count), 128'(0));
        check("t6_busy_cycles", 128'(busy_cycles), 128'(0));
        check("t6_cull_count", 128'(cull_count), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("t6_no_restart", 128'(tri_count), 128'(0));
        check("t6_idle", 128'(idle), 128'(1));
        check("t6_ready", 128'(bus.in_ready), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
